// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: registers decoded ID fields, bypasses EX/MEM and MEM/WB results into
// the EX operands, inserts a bubble on load-use hazards, and honours flush and downstream hold.

module id_ex_operand (
   input  logic        clk,
   input  logic        rst,
   input  logic        capture_i,
   input  logic        refresh_i,
   input  logic [4:0]  id_rs_i,
   input  logic [31:0] rf_read_i,
   input  logic        exmem_regwrite_i,
   input  logic        exmem_is_load_i,
   input  logic [4:0]  exmem_rd_i,
   input  logic [31:0] exmem_result_i,
   input  logic        memwb_regwrite_i,
   input  logic [4:0]  memwb_rd_i,
   input  logic [31:0] memwb_data_i,
   output logic [31:0] op_o
);
   logic [4:0]  rs_q, rs_d;
   logic [31:0] rdata_q, rdata_d;
   logic        wb_hit_id, wb_hit_ex, xm_hit;

   // The register file cannot show a write landing on the capture edge, so take it from the port.
   assign wb_hit_id = memwb_regwrite_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == id_rs_i);
   assign wb_hit_ex = memwb_regwrite_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == rs_q);
   assign xm_hit    = exmem_regwrite_i && !exmem_is_load_i && (exmem_rd_i == rs_q);

   always_comb begin
      rs_d    = rs_q;
      rdata_d = rdata_q;
      if (capture_i) begin
         rs_d    = id_rs_i;
         rdata_d = wb_hit_id ? memwb_data_i : rf_read_i;
      end else if (refresh_i && wb_hit_ex) begin
         rdata_d = memwb_data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs_q    <= 5'd0;
         rdata_q <= 32'd0;
      end else begin
         rs_q    <= rs_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      if (rs_q == 5'd0)
         op_o = 32'd0;
      else if (xm_hit)
         op_o = exmem_result_i;
      else if (memwb_regwrite_i && (memwb_rd_i == rs_q))
         op_o = memwb_data_i;
      else
         op_o = rdata_q;
   end
endmodule

module id_ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [31:0] id_pc,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [4:0]  id_rd,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic [31:0] id_imm,
   input  logic [15:0] id_ctrl,
   input  logic        id_is_load,
   input  logic [31:0] rf_read1,
   input  logic [31:0] rf_read2,
   input  logic        exmem_regwrite,
   input  logic        exmem_is_load,
   input  logic [4:0]  exmem_rd,
   input  logic [31:0] exmem_result,
   input  logic        memwb_regwrite,
   input  logic [4:0]  memwb_rd,
   input  logic [31:0] memwb_data,
   input  logic        flush,
   input  logic        ex_hold,
   output logic        stall_id,
   output logic        ex_valid,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_imm,
   output logic [4:0]  ex_rd,
   output logic [15:0] ex_ctrl,
   output logic        ex_is_load,
   output logic [31:0] ex_op1,
   output logic [31:0] ex_op2
);
   localparam int NUM_SRC = 2;

   logic        ex_valid_q, ex_valid_d;
   logic [31:0] ex_pc_q, ex_pc_d;
   logic [31:0] ex_imm_q, ex_imm_d;
   logic [4:0]  ex_rd_q, ex_rd_d;
   logic [15:0] ex_ctrl_q, ex_ctrl_d;
   logic        ex_is_load_q, ex_is_load_d;
   logic        lu, capture, refresh;

   logic [NUM_SRC-1:0][4:0]  src_rs;
   logic [NUM_SRC-1:0][31:0] src_rf;
   logic [NUM_SRC-1:0][31:0] src_op;

   assign src_rs = {id_rs2, id_rs1};
   assign src_rf = {rf_read2, rf_read1};

   assign lu = id_valid && ex_valid_q && ex_is_load_q && (ex_rd_q != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd_q)) || (id_uses_rs2 && (id_rs2 == ex_rd_q)));

   // Priority: flush, then hold, then load-use bubble, then normal capture.
   assign capture  = !flush && !ex_hold && !lu;
   assign refresh  = !flush && ex_hold;
   assign stall_id = !flush && (ex_hold || lu);

   always_comb begin
      ex_valid_d   = ex_valid_q;
      ex_pc_d      = ex_pc_q;
      ex_imm_d     = ex_imm_q;
      ex_rd_d      = ex_rd_q;
      ex_ctrl_d    = ex_ctrl_q;
      ex_is_load_d = ex_is_load_q;
      if (flush) begin
         ex_valid_d = 1'b0;
      end else if (ex_hold) begin
         ex_valid_d = ex_valid_q;
      end else if (lu) begin
         ex_valid_d   = 1'b0;
         ex_is_load_d = 1'b0;
      end else begin
         ex_valid_d   = id_valid;
         ex_pc_d      = id_pc;
         ex_imm_d     = id_imm;
         ex_rd_d      = id_rd;
         ex_ctrl_d    = id_ctrl;
         ex_is_load_d = id_is_load;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q   <= 1'b0;
         ex_pc_q      <= 32'd0;
         ex_imm_q     <= 32'd0;
         ex_rd_q      <= 5'd0;
         ex_ctrl_q    <= 16'd0;
         ex_is_load_q <= 1'b0;
      end else begin
         ex_valid_q   <= ex_valid_d;
         ex_pc_q      <= ex_pc_d;
         ex_imm_q     <= ex_imm_d;
         ex_rd_q      <= ex_rd_d;
         ex_ctrl_q    <= ex_ctrl_d;
         ex_is_load_q <= ex_is_load_d;
      end
   end

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      id_ex_operand u_opnd (
         .clk              (clk),
         .rst              (rst),
         .capture_i        (capture),
         .refresh_i        (refresh),
         .id_rs_i          (src_rs[s]),
         .rf_read_i        (src_rf[s]),
         .exmem_regwrite_i (exmem_regwrite),
         .exmem_is_load_i  (exmem_is_load),
         .exmem_rd_i       (exmem_rd),
         .exmem_result_i   (exmem_result),
         .memwb_regwrite_i (memwb_regwrite),
         .memwb_rd_i       (memwb_rd),
         .memwb_data_i     (memwb_data),
         .op_o             (src_op[s])
      );
   end

   assign ex_valid   = ex_valid_q;
   assign ex_pc      = ex_pc_q;
   assign ex_imm     = ex_imm_q;
   assign ex_rd      = ex_rd_q;
   assign ex_ctrl    = ex_ctrl_q;
   assign ex_is_load = ex_is_load_q;
   assign ex_op1     = src_op[0];
   assign ex_op2     = src_op[1];
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: operand-bypass vector table, hand sequences for reset/load-use/hold/flush,
// then random traffic against an architectural-register reference model.
module tb_id_ex_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_uses_rs1, id_uses_rs2, id_is_load;
   logic [31:0] id_pc, id_imm, rf_read1, rf_read2;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [15:0] id_ctrl;
   logic        exmem_regwrite, exmem_is_load, memwb_regwrite, flush, ex_hold;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_data;
   logic        stall_id, ex_valid, ex_is_load;
   logic [31:0] ex_pc, ex_imm, ex_op1, ex_op2;
   logic [4:0]  ex_rd;
   logic [15:0] ex_ctrl;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_imm(id_imm),
      .id_ctrl(id_ctrl), .id_is_load(id_is_load), .rf_read1(rf_read1), .rf_read2(rf_read2),
      .exmem_regwrite(exmem_regwrite), .exmem_is_load(exmem_is_load), .exmem_rd(exmem_rd),
      .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
      .memwb_data(memwb_data), .flush(flush), .ex_hold(ex_hold), .stall_id(stall_id),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
      .ex_is_load(ex_is_load), .ex_op1(ex_op1), .ex_op2(ex_op2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic idle();
      id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      id_imm = 0; id_ctrl = 0; id_is_load = 0; rf_read1 = 0; rf_read2 = 0;
      exmem_regwrite = 0; exmem_is_load = 0; exmem_rd = 0; exmem_result = 0;
      memwb_regwrite = 0; memwb_rd = 0; memwb_data = 0; flush = 0; ex_hold = 0;
   endtask

   // Operand-bypass table: capture an instruction, then check operands in its EX cycle.
   typedef struct {
      logic [4:0]  rs1, rs2;
      logic [31:0] rf1, rf2;
      logic        cwb_we; logic [4:0] cwb_rd; logic [31:0] cwb_d;
      logic        xm_we, xm_ld; logic [4:0] xm_rd; logic [31:0] xm_res;
      logic        wb_we; logic [4:0] wb_rd; logic [31:0] wb_d;
      logic [31:0] e1, e2;
   } vec_t;
   vec_t vt[10];

   // Reference model: EX contents plus the architectural register file the bench plays.
   typedef struct {
      logic v, ld; logic [31:0] pc, imm; logic [4:0] rd, rs1, rs2; logic [15:0] ctrl;
   } ex_t;
   ex_t m;
   logic [31:0] regs [32];

   // Newest architectural value of r as seen by an instruction in EX right now.
   function automatic logic [31:0] fresh(input logic [4:0] r);
      if (r == 0) return 32'd0;
      if (exmem_regwrite && !exmem_is_load && exmem_rd == r) return exmem_result;
      if (memwb_regwrite && memwb_rd == r) return memwb_data;
      return regs[r];
   endfunction

   initial begin
      logic m_lu;
      ex_t nx;
      vt[0] = '{5'd5, 5'd6, 32'h11, 32'h22, 1'b1, 5'd5, 32'hAB, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'hAB, 32'h22};
      vt[1] = '{5'd1, 5'd7, 32'h1, 32'h7, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd7, 32'h100, 1'b1, 5'd7, 32'h200, 32'h1, 32'h100};
      vt[2] = '{5'd1, 5'd7, 32'h1, 32'h7, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd7, 32'h100, 1'b1, 5'd7, 32'h200, 32'h1, 32'h200};
      vt[3] = '{5'd0, 5'd0, 32'h99, 32'h77, 1'b1, 5'd0, 32'h44, 1'b1, 1'b0, 5'd0, 32'h100, 1'b1, 5'd0, 32'h200, 32'h0, 32'h0};
      vt[4] = '{5'd3, 5'd4, 32'h3, 32'h4, 1'b1, 5'd4, 32'h444, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h3, 32'h444};
      vt[5] = '{5'd8, 5'd2, 32'h8, 32'h2, 1'b0, 5'd8, 32'h888, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h8, 32'h2};
      vt[6] = '{5'd10, 5'd2, 32'hA, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd10, 32'h5, 1'b0, 5'd0, 32'h0, 32'hA, 32'h2};
      vt[7] = '{5'd12, 5'd12, 32'hC, 32'hC, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd12, 32'hABC, 1'b1, 5'd12, 32'hDEF, 32'hABC, 32'hABC};
      vt[8] = '{5'd13, 5'd2, 32'hD, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hCAFE, 32'hCAFE, 32'h2};
      vt[9] = '{5'd14, 5'd15, 32'hE, 32'hF, 1'b1, 5'd15, 32'hF0, 1'b1, 1'b0, 5'd14, 32'hE0, 1'b0, 5'd0, 32'h0, 32'hE0, 32'hF0};

      idle(); rst = 1;
      #1;
      chk("rst_valid", 32'(ex_valid), 0); chk("rst_stall", 32'(stall_id), 0);
      chk("rst_op1", ex_op1, 0); chk("rst_op2", ex_op2, 0); chk("rst_pc", ex_pc, 0);
      @(negedge clk); rst = 0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk); idle();
         id_valid = 1; id_pc = 32'h1000 + 32'(i) * 4; id_rs1 = vt[i].rs1; id_rs2 = vt[i].rs2;
         rf_read1 = vt[i].rf1; rf_read2 = vt[i].rf2;
         memwb_regwrite = vt[i].cwb_we; memwb_rd = vt[i].cwb_rd; memwb_data = vt[i].cwb_d;
         @(negedge clk); idle();
         exmem_regwrite = vt[i].xm_we; exmem_is_load = vt[i].xm_ld; exmem_rd = vt[i].xm_rd;
         exmem_result = vt[i].xm_res;
         memwb_regwrite = vt[i].wb_we; memwb_rd = vt[i].wb_rd; memwb_data = vt[i].wb_d;
         #1;
         chk($sformatf("tbl%0d_valid", i), 32'(ex_valid), 1);
         chk($sformatf("tbl%0d_pc", i), ex_pc, 32'h1000 + 32'(i) * 4);
         chk($sformatf("tbl%0d_op1", i), ex_op1, vt[i].e1);
         chk($sformatf("tbl%0d_op2", i), ex_op2, vt[i].e2);
      end

      // Load-use: lw x3 in EX, add x4,x3,x3 in ID.
      @(negedge clk); idle(); id_valid = 1; id_is_load = 1; id_rd = 3; id_rs1 = 1; id_pc = 32'h200;
      @(negedge clk); idle(); id_valid = 1; id_rs1 = 3; id_rs2 = 3; id_uses_rs1 = 1; id_uses_rs2 = 1;
      id_rd = 4; id_pc = 32'h204;
      #1 chk("lu_stall", 32'(stall_id), 1);
      @(negedge clk); exmem_regwrite = 1; exmem_is_load = 1; exmem_rd = 3; exmem_result = 32'h1234;
      #1 chk("lu_bubble", 32'(ex_valid), 0); chk("lu_stall_once", 32'(stall_id), 0);
      @(negedge clk); idle(); memwb_regwrite = 1; memwb_rd = 3; memwb_data = 32'hDEAD;
      #1 chk("lu_dep_valid", 32'(ex_valid), 1); chk("lu_dep_pc", ex_pc, 32'h204);
      chk("lu_op1", ex_op1, 32'hDEAD); chk("lu_op2", ex_op2, 32'hDEAD);
      @(negedge clk); idle(); id_valid = 1; id_is_load = 1; id_rd = 3; id_pc = 32'h210;
      @(negedge clk); idle(); id_valid = 1; id_rs1 = 3; id_rs2 = 3; id_rd = 4;
      #1 chk("lu_nouse_stall", 32'(stall_id), 0);
      @(negedge clk); idle(); id_valid = 1; id_is_load = 1; id_rd = 6; id_pc = 32'h220;
      @(negedge clk); idle(); id_valid = 1; id_rs1 = 1; id_rs2 = 6; id_uses_rs2 = 1;
      #1 chk("lu_rs2_stall", 32'(stall_id), 1);

      // Hold for three cycles while x9 is written back.
      @(negedge clk); idle(); id_valid = 1; id_rs1 = 9; rf_read1 = 32'h9; id_pc = 32'h300;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); idle(); ex_hold = 1; id_valid = 1; id_rs1 = 1;
         if (k == 0) begin memwb_regwrite = 1; memwb_rd = 9; memwb_data = 32'h55; end
         #1 chk($sformatf("hold%0d_stall", k), 32'(stall_id), 1);
         chk($sformatf("hold%0d_pc", k), ex_pc, 32'h300);
      end
      @(negedge clk); idle();
      #1 chk("hold_op1", ex_op1, 32'h55); chk("hold_pc", ex_pc, 32'h300);
      chk("hold_release_stall", 32'(stall_id), 0);

      // Flush beats hold and load-use together.
      @(negedge clk); idle(); id_valid = 1; id_is_load = 1; id_rd = 3; id_pc = 32'h400;
      @(negedge clk); idle(); id_valid = 1; id_rs1 = 3; id_uses_rs1 = 1; ex_hold = 1; flush = 1;
      #1 chk("flush_stall", 32'(stall_id), 0);
      @(negedge clk); idle();
      #1 chk("flush_valid", 32'(ex_valid), 0);

      // Reset asserted mid-stall, then first edge after release captures normally.
      @(negedge clk); idle(); id_valid = 1; id_is_load = 1; id_rd = 3; id_rs1 = 2; rf_read1 = 32'h77; id_pc = 32'h500;
      @(negedge clk); idle(); id_valid = 1; id_rs1 = 3; id_uses_rs1 = 1;
      #1 chk("prerst_stall", 32'(stall_id), 1); chk("prerst_op1", ex_op1, 32'h77);
      #2 rst = 1;
      #1 chk("midrst_valid", 32'(ex_valid), 0); chk("midrst_stall", 32'(stall_id), 0);
      chk("midrst_op1", ex_op1, 0);
      @(negedge clk); rst = 0; idle(); id_valid = 1; id_rs1 = 2; rf_read1 = 32'h22; id_pc = 32'h600;
      @(negedge clk); idle();
      #1 chk("postrst_valid", 32'(ex_valid), 1); chk("postrst_pc", ex_pc, 32'h600);
      chk("postrst_op1", ex_op1, 32'h22);

      // Random traffic against the model.
      @(negedge clk); rst = 1; idle();
      #1 rst = 0;
      m = '{1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 16'd0};
      regs[0] = 0;
      for (int r = 1; r < 32; r++) regs[r] = $urandom;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         id_valid = ($urandom_range(9) < 8); id_pc = $urandom; id_imm = $urandom; id_ctrl = 16'($urandom);
         id_rs1 = 5'($urandom_range(7)); id_rs2 = 5'($urandom_range(7)); id_rd = 5'($urandom_range(7));
         id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom); id_is_load = ($urandom_range(9) < 3);
         rf_read1 = regs[id_rs1]; rf_read2 = regs[id_rs2];
         exmem_regwrite = 1'($urandom); exmem_is_load = ($urandom_range(3) == 0);
         exmem_rd = 5'($urandom_range(7)); exmem_result = $urandom;
         memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(7)); memwb_data = $urandom;
         flush = ($urandom_range(99) < 8); ex_hold = ($urandom_range(99) < 15);
         #1;
         m_lu = id_valid && m.v && m.ld && m.rd != 0 &&
                ((id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd));
         chk("rnd_stall", 32'(stall_id), 32'(!flush && (ex_hold || m_lu)));
         chk("rnd_valid", 32'(ex_valid), 32'(m.v));
         if (m.v) begin
            chk("rnd_pc", ex_pc, m.pc); chk("rnd_imm", ex_imm, m.imm);
            chk("rnd_rd", 32'(ex_rd), 32'(m.rd)); chk("rnd_ctrl", 32'(ex_ctrl), 32'(m.ctrl));
            chk("rnd_ld", 32'(ex_is_load), 32'(m.ld));
            chk("rnd_op1", ex_op1, fresh(m.rs1)); chk("rnd_op2", ex_op2, fresh(m.rs2));
         end
         nx = m;
         if (flush) nx.v = 0;
         else if (ex_hold) nx = m;
         else if (m_lu) begin nx.v = 0; nx.ld = 0; end
         else nx = '{id_valid, id_is_load, id_pc, id_imm, id_rd, id_rs1, id_rs2, id_ctrl};
         @(posedge clk);
         m = nx;
         if (memwb_regwrite && memwb_rd != 0) regs[memwb_rd] = memwb_data;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
